// File: rtl/wb_arbiter2.sv
// Two-master, one-slave arbiter for the pipelined Wishbone bus. Grants are held
// per packet and outstanding transfers are counted so every ack reaches its issuer.
module wb_arbiter2 #(
  parameter int OUTW = 4,
  parameter bit FAIR = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_dat_o,
  output logic        m0_ack,
  output logic        m0_stall,
  output logic [31:0] m0_dat_i,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_dat_o,
  output logic        m1_ack,
  output logic        m1_stall,
  output logic [31:0] m1_dat_i,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [3:0]  s_sel,
  output logic [31:0] s_dat_o,
  input  logic        s_ack,
  input  logic        s_stall,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {S_IDLE, S_M0, S_M1, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [OUTW-1:0] count_q, count_d;
  logic            last_m1_q, last_m1_d;
  logic            drain_m1_q, drain_m1_d;

  logic        own_m0, own_m1, active;
  logic        sel_cyc, sel_stb, sel_we;
  logic [31:0] sel_adr, sel_dat;
  logic [3:0]  sel_sel;
  logic        cnt_full, stb_fwd, accept, ack_valid;

  // Ownership covers both the active grant and the drain phase.
  assign own_m0 = (state_q == S_M0) || ((state_q == S_DRAIN) && !drain_m1_q);
  assign own_m1 = (state_q == S_M1) || ((state_q == S_DRAIN) &&  drain_m1_q);
  assign active = (state_q == S_M0) || (state_q == S_M1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_sel = '0;
    sel_dat = '0;
    if (state_q == S_M0) begin
      sel_cyc = m0_cyc;
      sel_stb = m0_stb;
      sel_we  = m0_we;
      sel_adr = m0_adr;
      sel_sel = m0_sel;
      sel_dat = m0_dat_o;
    end else if (state_q == S_M1) begin
      sel_cyc = m1_cyc;
      sel_stb = m1_stb;
      sel_we  = m1_we;
      sel_adr = m1_adr;
      sel_sel = m1_sel;
      sel_dat = m1_dat_o;
    end
  end

  assign cnt_full  = (count_q == {OUTW{1'b1}});
  assign stb_fwd   = sel_cyc & sel_stb & ~cnt_full;
  assign accept    = stb_fwd & ~s_stall;
  // An ack with nothing outstanding is a slave protocol error and is swallowed.
  assign ack_valid = s_ack & (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({accept, ack_valid})
      2'b10:   count_d = count_q + OUTW'(1);
      2'b01:   count_d = count_q - OUTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_m1_d  = last_m1_q;
    drain_m1_d = drain_m1_q;
    case (state_q)
      S_IDLE: begin
        if (m0_cyc && m1_cyc)  state_d = (FAIR && last_m1_q) ? S_M0 : S_M1;
        else if (m0_cyc)       state_d = S_M0;
        else if (m1_cyc)       state_d = S_M1;
      end
      S_M0, S_M1: begin
        if (!sel_cyc) begin
          if (count_d == '0) begin
            state_d   = S_IDLE;
            last_m1_d = (state_q == S_M1);
          end else begin
            state_d    = S_DRAIN;
            drain_m1_d = (state_q == S_M1);
          end
        end
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d   = S_IDLE;
          last_m1_d = drain_m1_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      last_m1_q  <= 1'b1;
      drain_m1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      last_m1_q  <= last_m1_d;
      drain_m1_q <= drain_m1_d;
    end
  end

  // The slave keeps cyc while anything is outstanding, including during drain.
  assign s_cyc   = sel_cyc | (count_q != '0);
  assign s_stb   = stb_fwd;
  assign s_we    = sel_we;
  assign s_adr   = sel_adr;
  assign s_sel   = sel_sel;
  assign s_dat_o = sel_dat;

  assign m0_ack   = own_m0 & ack_valid;
  assign m1_ack   = own_m1 & ack_valid;
  assign m0_dat_i = own_m0 ? s_dat_i : '0;
  assign m1_dat_i = own_m1 ? s_dat_i : '0;
  assign m0_stall = (state_q != S_M0) | s_stall | cnt_full;
  assign m1_stall = (state_q != S_M1) | s_stall | cnt_full;
  assign owner    = {own_m1, own_m0};

  logic unused_active;
  assign unused_active = active;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: a round-robin instance with a 2-bit counter and
// a fixed-priority instance share all inputs; expected values are hand-derived.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat_o, m1_adr, m1_dat_o, s_dat_i;
  logic [3:0]  m0_sel, m1_sel;
  logic        s_ack, s_stall;

  logic        f_m0_ack, f_m0_stall, f_m1_ack, f_m1_stall;
  logic [31:0] f_m0_dat_i, f_m1_dat_i, f_s_adr, f_s_dat_o;
  logic        f_s_cyc, f_s_stb, f_s_we;
  logic [3:0]  f_s_sel;
  logic [1:0]  f_owner;

  logic        p_m0_ack, p_m0_stall, p_m1_ack, p_m1_stall;
  logic [31:0] p_m0_dat_i, p_m1_dat_i, p_s_adr, p_s_dat_o;
  logic        p_s_cyc, p_s_stb, p_s_we;
  logic [3:0]  p_s_sel;
  logic [1:0]  p_owner;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.OUTW(2), .FAIR(1'b1)) dut_f (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_o(m0_dat_o),
    .m0_ack(f_m0_ack), .m0_stall(f_m0_stall), .m0_dat_i(f_m0_dat_i),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_o(m1_dat_o),
    .m1_ack(f_m1_ack), .m1_stall(f_m1_stall), .m1_dat_i(f_m1_dat_i),
    .s_cyc(f_s_cyc), .s_stb(f_s_stb), .s_we(f_s_we), .s_adr(f_s_adr),
    .s_sel(f_s_sel), .s_dat_o(f_s_dat_o),
    .s_ack(s_ack), .s_stall(s_stall), .s_dat_i(s_dat_i),
    .owner(f_owner)
  );

  wb_arbiter2 #(.OUTW(4), .FAIR(1'b0)) dut_p (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_o(m0_dat_o),
    .m0_ack(p_m0_ack), .m0_stall(p_m0_stall), .m0_dat_i(p_m0_dat_i),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_o(m1_dat_o),
    .m1_ack(p_m1_ack), .m1_stall(p_m1_stall), .m1_dat_i(p_m1_dat_i),
    .s_cyc(p_s_cyc), .s_stb(p_s_stb), .s_we(p_s_we), .s_adr(p_s_adr),
    .s_sel(p_s_sel), .s_dat_o(p_s_dat_o),
    .s_ack(s_ack), .s_stall(s_stall), .s_dat_i(s_dat_i),
    .owner(p_owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = 4'hF; m0_dat_o = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = 4'hF; m1_dat_o = '0;
    s_ack = 0; s_stall = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    settle();
  endtask

  initial begin
    do_reset();
    check("rst_owner",    f_owner,    2'b00);
    check("rst_s_cyc",    f_s_cyc,    1'b0);
    check("rst_s_stb",    f_s_stb,    1'b0);
    check("rst_m0_stall", f_m0_stall, 1'b1);
    check("rst_m1_stall", f_m1_stall, 1'b1);
    check("rst_m0_ack",   f_m0_ack,   1'b0);

    // Single master: three pipelined reads, slave acks one cycle after accept.
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; settle();
    check("sm_req_owner", f_owner, 2'b00);
    check("sm_req_stb",   f_s_stb, 1'b0);
    tick();
    check("sm_grant_owner", f_owner,    2'b01);
    check("sm_grant_stb",   f_s_stb,    1'b1);
    check("sm_grant_adr",   f_s_adr,    32'h100);
    check("sm_grant_stall", f_m0_stall, 1'b0);
    tick();
    m0_adr = 32'h104; s_ack = 1; s_dat_i = 32'hD0; settle();
    check("sm_ack0",     f_m0_ack,   1'b1);
    check("sm_dat0",     f_m0_dat_i, 32'hD0);
    check("sm_m1_ack0",  f_m1_ack,   1'b0);
    check("sm_m1_dat0",  f_m1_dat_i, 32'h0);
    check("sm_adr1",     f_s_adr,    32'h104);
    tick();
    m0_adr = 32'h108; s_dat_i = 32'hD1; settle();
    check("sm_dat1", f_m0_dat_i, 32'hD1);
    check("sm_adr2", f_s_adr,    32'h108);
    tick();
    m0_stb = 0; s_dat_i = 32'hD2; settle();
    check("sm_ack2", f_m0_ack,   1'b1);
    check("sm_dat2", f_m0_dat_i, 32'hD2);
    tick();
    m0_cyc = 0; s_ack = 0; settle();
    check("sm_end_cyc", f_s_cyc,  1'b0);
    check("sm_end_ack", f_m0_ack, 1'b0);
    tick();
    check("sm_idle_owner", f_owner, 2'b00);

    // Tie from reset: round-robin grants m0 first, fixed priority grants m1.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h200;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
    tick();
    check("rr_first_owner", f_owner,    2'b01);
    check("rr_first_adr",   f_s_adr,    32'h200);
    check("rr_m1_stall",    f_m1_stall, 1'b1);
    check("fp_first_owner", p_owner,    2'b10);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 1; s_dat_i = 32'hAAAA; settle();
    check("rr_m0_ack", f_m0_ack, 1'b1);
    check("rr_m1_ack", f_m1_ack, 1'b0);
    tick();
    s_ack = 0; settle();
    check("rr_gap_owner", f_owner,    2'b00);
    check("rr_gap_stall", f_m1_stall, 1'b1);
    tick();
    check("rr_second_owner", f_owner, 2'b10);
    check("rr_second_adr",   f_s_adr, 32'h300);
    m1_cyc = 0; m1_stb = 0;
    tick();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    check("rr_third_owner", f_owner, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    tick();

    // Fixed priority: m1 wins every tie.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_cyc = 1; m1_cyc = 1;
      tick();
      check($sformatf("fp_tie%0d_owner", i), p_owner, 2'b10);
      m0_cyc = 0; m1_cyc = 0;
      tick();
    end

    // Drain: m1 drops cyc with two reads outstanding while m0 waits.
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h400;
    tick();
    check("dr_stb", f_s_stb, 1'b1);
    tick();
    m1_adr = 32'h404;
    tick();
    m1_cyc = 0; m1_stb = 0; m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500; settle();
    check("dr_drop_cyc",   f_s_cyc, 1'b1);
    check("dr_drop_owner", f_owner, 2'b10);
    tick();
    check("dr_cyc",      f_s_cyc,    1'b1);
    check("dr_stb0",     f_s_stb,    1'b0);
    check("dr_m0_stall", f_m0_stall, 1'b1);
    check("dr_owner",    f_owner,    2'b10);
    s_ack = 1; s_dat_i = 32'hA1; settle();
    check("dr_ack1",    f_m1_ack,   1'b1);
    check("dr_dat1",    f_m1_dat_i, 32'hA1);
    check("dr_m0_ack1", f_m0_ack,   1'b0);
    tick();
    s_dat_i = 32'hB2; settle();
    check("dr_ack2", f_m1_ack,   1'b1);
    check("dr_dat2", f_m1_dat_i, 32'hB2);
    tick();
    s_ack = 0; settle();
    check("dr_idle_owner", f_owner,    2'b00);
    check("dr_idle_stall", f_m0_stall, 1'b1);
    tick();
    check("dr_m0_owner", f_owner, 2'b01);
    check("dr_m0_adr",   f_s_adr, 32'h500);

    // Counter full with a 2-bit counter: three outstanding transfers max.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h600;
    tick();
    s_stall = 1; settle();
    check("cf_slave_stall", f_m0_stall, 1'b1);
    tick();
    s_stall = 0; settle();
    check("cf_stall0", f_m0_stall, 1'b0);
    tick();
    tick();
    tick();
    check("cf_full_stall", f_m0_stall, 1'b1);
    check("cf_full_stb",   f_s_stb,    1'b0);
    s_ack = 1; settle();
    check("cf_full_ack_stall", f_m0_stall, 1'b1);
    tick();
    s_ack = 0; settle();
    check("cf_room_stall", f_m0_stall, 1'b0);
    check("cf_room_stb",   f_s_stb,    1'b1);
    tick();
    check("cf_refull_stall", f_m0_stall, 1'b1);
    s_ack = 1;
    tick();
    settle();
    check("cf_two_stb", f_s_stb, 1'b1);
    tick();
    s_ack = 0; settle();
    check("cf_same_stall", f_m0_stall, 1'b0);
    check("cf_same_stb",   f_s_stb,    1'b1);
    tick();
    check("cf_last_stall", f_m0_stall, 1'b1);

    // Reset with two transfers outstanding; a late ack must vanish.
    s_ack = 1;
    tick();
    s_ack = 0; m0_stb = 0;
    tick();
    rst_i = 1;
    tick();
    rst_i = 0; m0_cyc = 0; settle();
    check("rm_owner", f_owner, 2'b00);
    check("rm_cyc",   f_s_cyc, 1'b0);
    s_ack = 1; s_dat_i = 32'hDEAD; settle();
    check("rm_m0_ack", f_m0_ack, 1'b0);
    check("rm_m1_ack", f_m1_ack, 1'b0);
    tick();
    s_ack = 0; m0_cyc = 1; m0_stb = 1;
    tick();
    check("rm_regrant_owner", f_owner,    2'b01);
    check("rm_regrant_stall", f_m0_stall, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
